time_config: RTL
================

TIME_CONFIG -- requirements
Module: time_config

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000, meaning the number of idle clk cycles in a set mode before that mode is abandoned.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port btn_mode  input  1  one-cycle, debounced pulse that advances the configuration mode.
REQ-005 SHALL have port btn_next  input  1  one-cycle pulse that selects the next field.
REQ-006 SHALL have port btn_inc  input  1  one-cycle pulse that increments the selected field.
REQ-007 SHALL have port btn_dec  input  1  one-cycle pulse that decrements the selected field.
REQ-008 SHALL have port clock_time  input  24  current time as BCD {hh,mm,ss}, 8 bits per field.
REQ-009 SHALL have port conf_stat  output  2  mode: 00 idle, 01 set time, 10 set alarm.
REQ-010 SHALL have port conf_time  output  24  BCD {hh,mm,ss} value under edit.
REQ-011 SHALL have port conf_pulse  output  1  one-cycle strobe asserted in every cycle that conf_time takes a new value.
REQ-012 SHALL have port field_sel  output  2  selected field: 0 hour, 1 minute, 2 second.
REQ-013 SHALL have port load_time  output  1  one-cycle strobe that commits new_time to the clock counter.
REQ-014 SHALL have port new_time  output  24  BCD time to be loaded into the clock counter.
REQ-015 SHALL have port alarm_time  output  24  stored BCD alarm time.
REQ-016 SHALL have port alarm_en  output  1  alarm armed.

Function
REQ-017 SHALL implement a state machine with states IDLE, SET_TIME and SET_ALARM, encoded directly on conf_stat (00, 01, 10); conf_stat SHALL never take the value 11.
REQ-018 On btn_mode in IDLE, SHALL move to SET_TIME, load conf_time with clock_time, set field_sel to 0, and pulse conf_pulse.
REQ-019 On btn_mode in SET_TIME, SHALL move to SET_ALARM, set new_time to conf_time, pulse load_time for one cycle, load conf_time with alarm_time, set field_sel to 0, and pulse conf_pulse.
REQ-020 On btn_mode in SET_ALARM, SHALL move to IDLE, set alarm_time to conf_time, and set alarm_en to 1.
REQ-021 On btn_next in a set state, field_sel SHALL cycle 0 -> 1 -> 2 -> 0; btn_next SHALL be ignored in IDLE.
REQ-022 On btn_inc in a set state, the selected field SHALL increment in BCD: hour wraps 23 -> 00; minute and second wrap 59 -> 00; low digit 9 carries into the high digit.
REQ-023 On btn_dec in a set state, the selected field SHALL decrement in BCD: hour wraps 00 -> 23; minute and second wrap 00 -> 59; low digit 0 borrows from the high digit.
REQ-024 Unselected fields SHALL be unchanged by btn_inc or btn_dec.
REQ-025 Every edit of conf_time SHALL assert conf_pulse in the same cycle as the registered update.
REQ-026 Simultaneous button priority SHALL be btn_mode > btn_next > (btn_inc xor btn_dec); btn_inc and btn_dec asserted together SHALL produce no edit.
REQ-027 btn_inc and btn_dec SHALL be ignored in IDLE.
REQ-028 All outputs SHALL be registered, with update latency of one clk edge after the button pulse.
REQ-029 An inactivity counter SHALL clear on any button pulse and on every state change, and SHALL count while in a set state.
REQ-030 When the inactivity counter reaches TIMEOUT-1, SHALL return to IDLE without commit: no load_time, and alarm_time and alarm_en unchanged.
REQ-031 In IDLE, conf_time SHALL hold its last value, and conf_pulse and load_time SHALL be 0.
REQ-032 Loading from clock_time or alarm_time SHALL be unconditional; entering a set state with an invalid BCD value SHALL pass that value through unchanged, and the first inc or dec on that field SHALL wrap it to 00 (inc) or to the field maximum (dec).

Reset
REQ-033 While rst is high, SHALL set conf_stat=00, conf_time=000000, conf_pulse=0, field_sel=0, load_time=0, new_time=000000, alarm_time=000000, alarm_en=0, and inactivity counter=0.
REQ-034 Reset asserted mid-edit SHALL discard the edit, with no load_time pulse.

Verification
REQ-035 Set time: clock_time=123456, then mode, next, inc, mode -> new_time=123556, load_time high for 1 cycle, conf_stat=10, conf_time=000000.
REQ-036 Hour wrap: in SET_TIME with hour=23, inc -> hour=00; then dec -> hour=23; conf_pulse high on both cycles.
REQ-037 Minute wrap: with field 1 and minute=59, inc -> 00; dec from 00 -> 59; hour and second unchanged.
REQ-038 Set alarm: complete the path to SET_ALARM, set hour to 07, then mode -> alarm_time=070000, alarm_en=1, conf_stat=00, no load_time.
REQ-039 Timeout: with TIMEOUT=8, in SET_TIME with no buttons for 8 cycles -> conf_stat=00, load_time never asserted, alarm_time unchanged.
REQ-040 Simultaneous and reset: mode with inc in the same cycle -> state advances, no edit; inc with dec in the same cycle -> no conf_pulse; rst asserted mid-edit -> all outputs at reset values immediately.

Source files
------------

// File: rtl/time_config.sv
// Button-driven editor for the running time and the alarm time. Edits live in
// conf_time and are only committed when the mode button advances past a set state.
module time_config #(
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [23:0] clock_time,
    output logic [1:0]  conf_stat,
    output logic [23:0] conf_time,
    output logic        conf_pulse,
    output logic [1:0]  field_sel,
    output logic        load_time,
    output logic [23:0] new_time,
    output logic [23:0] alarm_time,
    output logic        alarm_en
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SET_TIME  = 2'b01,
        SET_ALARM = 2'b10
    } state_t;

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    state_t        r_state,     w_state;
    logic [23:0]   r_confTime,  w_confTime;
    logic          r_confPulse, w_confPulse;
    logic [1:0]    r_fieldSel,  w_fieldSel;
    logic          r_loadTime,  w_loadTime;
    logic [23:0]   r_newTime,   w_newTime;
    logic [23:0]   r_alarmTime, w_alarmTime;
    logic          r_alarmEn,   w_alarmEn;
    logic [CW-1:0] r_idleCnt,   w_idleCnt;

    logic [7:0]    w_selField;
    logic [7:0]    w_fieldMax;
    logic [7:0]    w_newField;
    logic [23:0]   w_edited;

    // Out-of-range or non-BCD values snap to 00 so a bad loaded value is recoverable.
    function automatic logic [7:0] bcdInc(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] res;
        if (v[3:0] > 4'd9 || v >= vmax)
            res = 8'h00;
        else if (v[3:0] == 4'd9)
            res = {v[7:4] + 4'd1, 4'd0};
        else
            res = {v[7:4], v[3:0] + 4'd1};
        return res;
    endfunction

    function automatic logic [7:0] bcdDec(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] res;
        if (v[3:0] > 4'd9 || v > vmax || v == 8'h00)
            res = vmax;
        else if (v[3:0] == 4'd0)
            res = {v[7:4] - 4'd1, 4'd9};
        else
            res = {v[7:4], v[3:0] - 4'd1};
        return res;
    endfunction

    always_comb begin
        w_selField = conf_time[7:0];
        w_fieldMax = 8'h59;
        w_edited   = r_confTime;
        case (r_fieldSel)
            2'd0: begin
                w_selField = r_confTime[23:16];
                w_fieldMax = 8'h23;
            end
            2'd1:    w_selField = r_confTime[15:8];
            default: w_selField = r_confTime[7:0];
        endcase
        w_newField = btn_inc ? bcdInc(w_selField, w_fieldMax) : bcdDec(w_selField, w_fieldMax);
        case (r_fieldSel)
            2'd0:    w_edited[23:16] = w_newField;
            2'd1:    w_edited[15:8]  = w_newField;
            default: w_edited[7:0]   = w_newField;
        endcase
    end

    // Button priority is mode, then next, then a lone inc/dec; quiet cycles feed the timeout.
    always_comb begin
        w_state     = r_state;
        w_confTime  = r_confTime;
        w_confPulse = 1'b0;
        w_fieldSel  = r_fieldSel;
        w_loadTime  = 1'b0;
        w_newTime   = r_newTime;
        w_alarmTime = r_alarmTime;
        w_alarmEn   = r_alarmEn;
        w_idleCnt   = r_idleCnt;
        case (r_state)
            IDLE: begin
                w_idleCnt = '0;
                if (btn_mode) begin
                    w_state     = SET_TIME;
                    w_confTime  = clock_time;
                    w_fieldSel  = 2'd0;
                    w_confPulse = 1'b1;
                end
            end
            SET_TIME, SET_ALARM: begin
                if (btn_mode) begin
                    w_idleCnt = '0;
                    if (r_state == SET_TIME) begin
                        w_state     = SET_ALARM;
                        w_newTime   = r_confTime;
                        w_loadTime  = 1'b1;
                        w_confTime  = r_alarmTime;
                        w_fieldSel  = 2'd0;
                        w_confPulse = 1'b1;
                    end else begin
                        w_state     = IDLE;
                        w_alarmTime = r_confTime;
                        w_alarmEn   = 1'b1;
                    end
                end else if (btn_next) begin
                    w_idleCnt  = '0;
                    w_fieldSel = (r_fieldSel == 2'd2) ? 2'd0 : r_fieldSel + 2'd1;
                end else if (btn_inc ^ btn_dec) begin
                    w_idleCnt   = '0;
                    w_confTime  = w_edited;
                    w_confPulse = 1'b1;
                end else if (btn_inc & btn_dec) begin
                    w_idleCnt = '0;
                end else if (r_idleCnt == LAST_CNT) begin
                    w_state   = IDLE;
                    w_idleCnt = '0;
                end else begin
                    w_idleCnt = r_idleCnt + 1'b1;
                end
            end
            default: begin
                w_state   = IDLE;
                w_idleCnt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_confTime  <= 24'h000000;
            r_confPulse <= 1'b0;
            r_fieldSel  <= 2'd0;
            r_loadTime  <= 1'b0;
            r_newTime   <= 24'h000000;
            r_alarmTime <= 24'h000000;
            r_alarmEn   <= 1'b0;
            r_idleCnt   <= '0;
        end else begin
            r_state     <= w_state;
            r_confTime  <= w_confTime;
            r_confPulse <= w_confPulse;
            r_fieldSel  <= w_fieldSel;
            r_loadTime  <= w_loadTime;
            r_newTime   <= w_newTime;
            r_alarmTime <= w_alarmTime;
            r_alarmEn   <= w_alarmEn;
            r_idleCnt   <= w_idleCnt;
        end
    end

    assign conf_stat  = r_state;
    assign conf_time  = r_confTime;
    assign conf_pulse = r_confPulse;
    assign field_sel  = r_fieldSel;
    assign load_time  = r_loadTime;
    assign new_time   = r_newTime;
    assign alarm_time = r_alarmTime;
    assign alarm_en   = r_alarmEn;

endmodule
